// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// Digit limits and the controller state encoding live here.
package stopwatch_pkg;

    localparam int BCD_W = 4;
    localparam int LIM_9 = 9;
    localparam int LIM_5 = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit with synchronous clear and carry out.
// Carry is combinational so a whole chain resolves in one cycle.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int LIMIT = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    localparam logic [BCD_W-1:0] LIM = BCD_W'(LIMIT);

    assign carry = inc & (q == LIM);

    // clear dominates; otherwise count up and roll over at LIMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == LIM) ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// M:SS.t stopwatch: control FSM, tick gating and terminal handling.
// Digits are four chained bcd_digit instances.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN   = 9,
    parameter int AUTO_WRAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic             pres_en,
    output logic [BCD_W-1:0] d0,
    output logic [BCD_W-1:0] d1,
    output logic [BCD_W-1:0] d2,
    output logic [BCD_W-1:0] d3,
    output logic             running,
    output logic             done
);

    localparam logic [BCD_W-1:0] L9  = BCD_W'(LIM_9);
    localparam logic [BCD_W-1:0] L5  = BCD_W'(LIM_5);
    localparam logic [BCD_W-1:0] LMX = BCD_W'(MAX_MIN);
    localparam bit               WRAP = (AUTO_WRAP != 0);

    state_t state;
    logic   terminal;
    logic   adv;
    logic   inc0;
    logic   c0, c1, c2, c3;
    logic   hit_end;

    assign terminal = (d3 == LMX) && (d2 == L5) &&
                      (d1 == L9) && (d0 == L9);

    // a tick only counts in RUN and loses to stop/clear
    assign adv  = (state == RUN) & tick & ~stop & ~clear;

    // in hold mode the counter freezes at the terminal value
    assign inc0 = adv & ~(!WRAP && terminal);

    // terminal tick: carry out of the top digit when wrapping,
    // otherwise the suppressed tick at the terminal value
    assign hit_end = WRAP ? c3 : (adv & terminal);

    bcd_digit #(.LIMIT(LIM_9)) u_d0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (inc0),
        .q     (d0),
        .carry (c0)
    );

    bcd_digit #(.LIMIT(LIM_9)) u_d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (c0),
        .q     (d1),
        .carry (c1)
    );

    bcd_digit #(.LIMIT(LIM_5)) u_d2 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (c1),
        .q     (d2),
        .carry (c2)
    );

    bcd_digit #(.LIMIT(MAX_MIN)) u_d3 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (c2),
        .q     (d3),
        .carry (c3)
    );

    // control FSM with registered status outputs; clear > stop > start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
            pres_en <= 1'b0;
            done    <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            running <= 1'b0;
            pres_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, PAUSE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                        pres_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                        pres_en <= 1'b0;
                    end else if (hit_end && !WRAP) begin
                        state   <= DONE;
                        running <= 1'b0;
                        pres_en <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    pres_en <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Downstream consumer of the prescaler tick: counts tenths of seconds as a 4-digit BCD stopwatch, format M:SS.t.
- Driven by start/stop/clear control pulses from the button front end.
- Drives the prescaler enable back upstream, so the prescaler only advances while the stopwatch runs.
- Digit outputs feed the seven-segment display mux.

Parameters:
- MAX_MIN, 9: highest minutes digit value; legal range 1..9.
- AUTO_WRAP, 1: 1 = wrap MAX_MIN:59.9 -> 0:00.0 and keep running; 0 = hold at MAX_MIN:59.9 and enter DONE.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle pulse from the prescaler, one per 0.1 s.
- start  input  1  one-cycle pulse: begin or resume counting.
- stop  input  1  one-cycle pulse: pause counting.
- clear  input  1  one-cycle pulse: zero all digits and return to IDLE.
- pres_en  output  1  enable to the upstream prescaler; high in RUN only.
- d0  output  4  tenths digit, 0..9.
- d1  output  4  seconds-ones digit, 0..9.
- d2  output  4  seconds-tens digit, 0..5.
- d3  output  4  minutes digit, 0..MAX_MIN.
- running  output  1  high in RUN.
- done  output  1  high in DONE (AUTO_WRAP=0 only).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; d0..d3 = 0; pres_en, running, done = 0. Outputs stay in reset until the first clk edge after rst_n deasserts.
- All outputs are registered. Digits update on the clk edge at which tick is sampled high in RUN, giving 1-cycle latency from tick to the digit change.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE --start--> RUN.
  - RUN --stop--> PAUSE.
  - PAUSE --start--> RUN.
  - RUN --terminal tick with AUTO_WRAP=0--> DONE.
  - Any state --clear--> IDLE.
- Control priority when pulses coincide in one cycle: clear > stop > start.
  - clear+start: go to IDLE, digits zeroed.
  - stop+start in RUN: go to PAUSE.
- Ignored inputs:
  - start in RUN or DONE has no effect.
  - stop in IDLE, PAUSE or DONE has no effect.
  - tick outside RUN has no effect.
- Counting on a tick in RUN (carry chain resolves combinationally within the cycle):
  - d0 increments; 9 -> 0 with carry into d1.
  - d1 increments on carry; 9 -> 0 with carry into d2.
  - d2 increments on carry; 5 -> 0 with carry into d3.
  - d3 increments on carry; MAX_MIN -> terminal handling.
- Terminal value is MAX_MIN:59.9.
  - AUTO_WRAP=1: the next tick loads 0:00.0 and the FSM stays in RUN.
  - AUTO_WRAP=0: the next tick leaves digits unchanged; state goes to DONE, done=1, pres_en=0.
- Same-cycle interactions:
  - tick coincident with clear: clear wins; digits go to 0, no increment.
  - tick coincident with stop in RUN: stop wins; no increment, go to PAUSE.
  - tick coincident with start in IDLE/PAUSE: no increment that cycle, since the state was not RUN when sampled.
- pres_en = (state == RUN), registered. The upstream prescaler freezes while paused, so resume does not produce a short first interval.
- Digits never take values outside their stated ranges. The implementation need not guard against illegal values, since none is reachable from reset.
- Reset asserted mid-count: immediate return to the reset values, no pending tick remembered.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum: IDLE, RUN, PAUSE, DONE.
  - BCD_W = 4.
  - constants for digit limits: 9, 5.
- Sub-module bcd_digit, instantiated four times:
  - parameter LIMIT.
  - ports: clk, rst_n, clr, inc, q[3:0], carry.
  - carry = inc & (q == LIMIT).
- Top level contains the FSM, the priority logic and the terminal/saturate logic.

Test Plan:
- Reset and run: hold rst_n low, check all outputs 0. Release, pulse start, apply 10 ticks -> d3..d0 = 0,0,1,0; running=1, pres_en=1.
- Pause: from 0:01.0, pulse stop, then 5 ticks -> digits unchanged, running=0, pres_en=0. Pulse start, then 1 tick -> 0:01.1.
- Carry chain: run to 0:59.9, apply 1 tick -> 1:00.0 exactly one cycle after the tick.
- Wrap: AUTO_WRAP=1, MAX_MIN=9; from 9:59.9, 1 tick -> 0:00.0, state still RUN.
- Saturate: AUTO_WRAP=0; from 9:59.9, 1 tick -> digits remain 9:59.9, done=1, pres_en=0. Further ticks and start have no effect; clear -> IDLE, 0:00.0, done=0.
- Collisions: clear+tick in the same cycle at 0:12.3 -> 0:00.0, IDLE. stop+tick in RUN -> no increment, PAUSE. Assert rst_n low mid-count -> outputs 0 immediately, without waiting for a clk edge.
